// File: rtl/pipeline_flush_ctrl_pkg.sv
// Shared types and helpers for the pipeline flush/redirect controller.
package pipeline_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        OFFER = 2'd2
    } flush_state_t;

    // Index width for an n-entry select, never narrower than one bit.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Stage index type for the default five-stage core.
    localparam int DefNumStages = 5;
    typedef logic [$clog2(DefNumStages)-1:0] stage_idx_t;

endpackage

// File: rtl/pipeline_flush_ctrl_if.sv
// Redirect request / flush / next-PC bundle between the pipeline stages,
// the flush controller and fetch.
interface pipeline_flush_ctrl_if
    import pipeline_pkg::*;
#(
    parameter int WordSize   = 32,
    parameter int NumStages  = 5,
    parameter int NumSources = 2,
    parameter int CountWidth = 16
);
    localparam int StageWidth = idx_bits(NumStages);

    logic [NumSources-1:0]                 redir_valid;
    logic [NumSources-1:0][WordSize-1:0]   redir_pc;
    logic [NumSources-1:0][StageWidth-1:0] redir_stage;
    logic [NumStages-1:0]                  stage_flush;
    logic                                  npc_valid;
    logic [WordSize-1:0]                   npc;
    logic                                  npc_ready;
    logic                                  busy;
    logic [CountWidth-1:0]                 flush_count;

    // Requesting side: stages raising redirects plus fetch accepting npc.
    modport master (
        output redir_valid, redir_pc, redir_stage, npc_ready,
        input  stage_flush, npc_valid, npc, busy, flush_count
    );

    // Controller side.
    modport slave (
        input  redir_valid, redir_pc, redir_stage, npc_ready,
        output stage_flush, npc_valid, npc, busy, flush_count
    );

endinterface

// File: rtl/pipeline_flush_ctrl_arbiter.sv
// Oldest-first select: among valid requests pick the highest stage index,
// lowest requester index on ties; out-of-range stage indices are ignored.
module redirect_arbiter
    import pipeline_pkg::*;
#(
    parameter int WordSize   = 32,
    parameter int NumStages  = 5,
    parameter int NumSources = 2,
    localparam int StageWidth = idx_bits(NumStages),
    localparam int SrcWidth   = idx_bits(NumSources)
)(
    input  logic [NumSources-1:0]                 req_valid,
    input  logic [NumSources-1:0][WordSize-1:0]   req_pc,
    input  logic [NumSources-1:0][StageWidth-1:0] req_stage,
    output logic                                  win_valid,
    output logic [SrcWidth-1:0]                   win_idx,
    output logic [WordSize-1:0]                   win_pc,
    output logic [StageWidth-1:0]                 win_stage
);

    // Linear scan; strict '>' keeps the lower index on equal stages.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        win_pc    = '0;
        win_stage = '0;
        for (int i = 0; i < NumSources; i++) begin
            if (req_valid[i] && (int'(req_stage[i]) < NumStages) &&
                (!win_valid || (req_stage[i] > win_stage))) begin
                win_valid = 1'b1;
                win_idx   = SrcWidth'(i);
                win_pc    = req_pc[i];
                win_stage = req_stage[i];
            end
        end
    end

endmodule

// File: rtl/pipeline_flush_ctrl.sv
// Flush/redirect controller: accepts the oldest redirect, holds a flush mask
// over the younger stages for FlushCycles cycles, then offers the corrected
// PC to fetch. Older redirects preempt an in-progress flush or offer.
//
//  state | meaning
//  IDLE  | no redirect in progress
//  FLUSH | flush mask asserted, hold counter running down
//  OFFER | npc_valid asserted, waiting for npc_ready
module pipeline_flush_ctrl
    import pipeline_pkg::*;
#(
    parameter int WordSize    = 32,
    parameter int NumStages   = 5,
    parameter int NumSources  = 2,
    parameter int FlushCycles = 1,
    parameter int CountWidth  = 16
)(
    input logic                   clk,
    input logic                   rst,
    pipeline_flush_ctrl_if.slave  bus
);

    localparam int StageWidth = idx_bits(NumStages);
    localparam int SrcWidth   = idx_bits(NumSources);
    localparam int HoldWidth  = idx_bits(FlushCycles);
    localparam logic [HoldWidth-1:0] HoldLoad = HoldWidth'(FlushCycles - 1);

    flush_state_t          state_q, state_d;
    logic [WordSize-1:0]   pc_q;
    logic [StageWidth-1:0] stage_q;
    logic [HoldWidth-1:0]  hold_q;
    logic [CountWidth-1:0] count_q;

    logic                  win_valid;
    logic [SrcWidth-1:0]   win_idx;
    logic [WordSize-1:0]   win_pc;
    logic [StageWidth-1:0] win_stage;
    logic                  accept;

    redirect_arbiter #(
        .WordSize   (WordSize),
        .NumStages  (NumStages),
        .NumSources (NumSources)
    ) u_arb (
        .req_valid (bus.redir_valid),
        .req_pc    (bus.redir_pc),
        .req_stage (bus.redir_stage),
        .win_valid (win_valid),
        .win_idx   (win_idx),
        .win_pc    (win_pc),
        .win_stage (win_stage)
    );

    // In IDLE any redirect is taken; otherwise only a strictly older one,
    // since younger or equal stages are already covered by the flush.
    assign accept = win_valid && ((state_q == IDLE) || (win_stage > stage_q));

    // The reported winner must always be one of the asserted requesters.
    always_comb begin
        if (win_valid) begin
            assert (bus.redir_valid[win_idx]);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; a preempt in OFFER overrides a same-cycle handshake.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) state_d = FLUSH;
            end
            FLUSH: begin
                if (accept)              state_d = FLUSH;
                else if (hold_q == '0)   state_d = OFFER;
            end
            OFFER: begin
                if (accept)              state_d = FLUSH;
                else if (bus.npc_ready)  state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Latched redirect, hold counter and saturating accept counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= '0;
            stage_q <= '0;
            hold_q  <= '0;
            count_q <= '0;
        end else if (accept) begin
            pc_q    <= win_pc;
            stage_q <= win_stage;
            hold_q  <= HoldLoad;
            if (count_q != '1) count_q <= count_q + CountWidth'(1);
        end else if ((state_q == FLUSH) && (hold_q != '0)) begin
            hold_q <= hold_q - HoldWidth'(1);
        end
    end

    // Outputs decode registered state only, so there is no input-to-output path.
    always_comb begin
        bus.stage_flush = '0;
        bus.npc_valid   = 1'b0;
        bus.busy        = (state_q != IDLE);
        if (state_q == FLUSH) begin
            for (int k = 0; k < NumStages; k++) begin
                bus.stage_flush[k] = (k < int'(stage_q));
            end
        end
        if (state_q == OFFER) begin
            bus.npc_valid = 1'b1;
        end
    end

    assign bus.npc         = pc_q;
    assign bus.flush_count = count_q;

endmodule

// File: tb/tb_pipeline_flush_ctrl.sv
// Bench for pipeline_flush_ctrl: vector table plus hand-written backpressure
// and preemption sequences; npc handshakes are checked against a queue.
module tb_pipeline_flush_ctrl;
    import pipeline_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]             r_valid;
    logic [1:0][31:0]       r_pc;
    logic [1:0][2:0]        r_stage;
    logic                   ready;

    pipeline_flush_ctrl_if #(.WordSize(32), .NumStages(5), .NumSources(2), .CountWidth(16)) bus ();
    pipeline_flush_ctrl_if #(.WordSize(32), .NumStages(5), .NumSources(2), .CountWidth(2))  bus_sat ();

    assign bus.redir_valid     = r_valid;
    assign bus.redir_pc        = r_pc;
    assign bus.redir_stage     = r_stage;
    assign bus.npc_ready       = ready;
    assign bus_sat.redir_valid = r_valid;
    assign bus_sat.redir_pc    = r_pc;
    assign bus_sat.redir_stage = r_stage;
    assign bus_sat.npc_ready   = ready;

    pipeline_flush_ctrl #(.WordSize(32), .NumStages(5), .NumSources(2),
                          .FlushCycles(2), .CountWidth(16)) dut (
        .clk (clk), .rst (rst), .bus (bus)
    );

    pipeline_flush_ctrl #(.WordSize(32), .NumStages(5), .NumSources(2),
                          .FlushCycles(2), .CountWidth(2)) dut_sat (
        .clk (clk), .rst (rst), .bus (bus_sat)
    );

    typedef struct {
        logic [1:0]  valid;
        logic [31:0] pc0;
        stage_idx_t  st0;
        logic [31:0] pc1;
        stage_idx_t  st1;
        logic        acc;
        logic [4:0]  mask;
        logic [31:0] npc;
    } vec_t;

    vec_t        vecs [8];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          exp_count = 0;
    logic [31:0] sb_q [$];
    logic        suppress_hs = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat_exp(input int n);
        return (n > 3) ? 3 : n;
    endfunction

    task automatic check_counts(input string tag);
        check({tag, "_count"}, 32'(bus.flush_count), 32'(exp_count));
        check({tag, "_sat_count"}, 32'(bus_sat.flush_count), 32'(sat_exp(exp_count)));
    endtask

    // Scoreboard: every completed handshake must match the oldest pending npc.
    always @(negedge clk) begin
        if (!rst && bus.npc_valid && bus.npc_ready && !suppress_hs) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: got npc 0x%0h with no pending redirect", bus.npc);
            end else begin
                check("sb_npc", bus.npc, sb_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{2'b01, 32'h100, 3'd3, 32'h0,   3'd0, 1'b1, 5'b00111, 32'h100};
        vecs[1] = '{2'b11, 32'h200, 3'd2, 32'h400, 3'd4, 1'b1, 5'b01111, 32'h400};
        vecs[2] = '{2'b11, 32'h222, 3'd2, 32'h333, 3'd2, 1'b1, 5'b00011, 32'h222};
        vecs[3] = '{2'b10, 32'h999, 3'd4, 32'h510, 3'd1, 1'b1, 5'b00001, 32'h510};
        vecs[4] = '{2'b01, 32'h600, 3'd0, 32'h0,   3'd0, 1'b1, 5'b00000, 32'h600};
        vecs[5] = '{2'b11, 32'hdead, 3'd5, 32'h710, 3'd1, 1'b1, 5'b00001, 32'h710};
        vecs[6] = '{2'b11, 32'hbeef, 3'd7, 32'h8a0, 3'd4, 1'b1, 5'b01111, 32'h8a0};
        vecs[7] = '{2'b01, 32'hf00, 3'd6, 32'h0,   3'd0, 1'b0, 5'b00000, 32'h0};

        // Reset held two cycles with a live redirect.
        rst = 1'b1;
        ready = 1'b1;
        r_valid = 2'b01;
        r_pc[0] = 32'h55;  r_stage[0] = 3'd3;
        r_pc[1] = 32'h0;   r_stage[1] = 3'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_flush", 32'(bus.stage_flush), 32'h0);
        check("rst_npc_valid", 32'(bus.npc_valid), 32'h0);
        check("rst_npc", bus.npc, 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check_counts("rst");
        step();
        rst = 1'b0;
        r_valid = 2'b00;
        @(negedge clk);
        step();
        @(negedge clk);
        check("post_rst_busy", 32'(bus.busy), 32'h0);
        check_counts("post_rst");

        // Table: one-cycle redirect, ready held high throughout.
        for (int i = 0; i < 8; i++) begin
            step();
            r_valid = vecs[i].valid;
            r_pc[0] = vecs[i].pc0;  r_stage[0] = vecs[i].st0;
            r_pc[1] = vecs[i].pc1;  r_stage[1] = vecs[i].st1;
            if (vecs[i].acc) begin
                sb_q.push_back(vecs[i].npc);
                exp_count++;
            end
            step();
            r_valid = 2'b00;
            @(negedge clk);
            if (vecs[i].acc) begin
                check($sformatf("v%0d_mask_c1", i), 32'(bus.stage_flush), 32'(vecs[i].mask));
                check($sformatf("v%0d_busy_c1", i), 32'(bus.busy), 32'h1);
                step();
                @(negedge clk);
                check($sformatf("v%0d_mask_c2", i), 32'(bus.stage_flush), 32'(vecs[i].mask));
                check($sformatf("v%0d_nv_c2", i), 32'(bus.npc_valid), 32'h0);
                step();
                @(negedge clk);
                check($sformatf("v%0d_nv_c3", i), 32'(bus.npc_valid), 32'h1);
                check($sformatf("v%0d_npc_c3", i), bus.npc, vecs[i].npc);
                check($sformatf("v%0d_flush_c3", i), 32'(bus.stage_flush), 32'h0);
            end else begin
                check($sformatf("v%0d_busy_ignored", i), 32'(bus.busy), 32'h0);
                check($sformatf("v%0d_mask_ignored", i), 32'(bus.stage_flush), 32'h0);
            end
            step();
            @(negedge clk);
            check($sformatf("v%0d_idle", i), 32'(bus.busy), 32'h0);
            check_counts($sformatf("v%0d", i));
        end

        // Backpressure: five OFFER cycles with ready low, then handshake.
        step();
        ready = 1'b0;
        r_valid = 2'b01;  r_pc[0] = 32'habc;  r_stage[0] = 3'd3;
        sb_q.push_back(32'habc);
        exp_count++;
        step();
        r_valid = 2'b00;
        step();
        for (int c = 0; c < 5; c++) begin
            step();
            @(negedge clk);
            check($sformatf("bp_nv_%0d", c), 32'(bus.npc_valid), 32'h1);
            check($sformatf("bp_npc_%0d", c), bus.npc, 32'habc);
        end
        step();
        ready = 1'b1;
        @(negedge clk);
        step();
        @(negedge clk);
        check("bp_nv_after", 32'(bus.npc_valid), 32'h0);
        check("bp_busy_after", 32'(bus.busy), 32'h0);
        check("bp_queue", 32'(sb_q.size()), 32'h0);

        // Preempt during FLUSH; a younger redirect afterwards is dropped.
        step();
        r_valid = 2'b01;  r_pc[0] = 32'h1200;  r_stage[0] = 3'd2;
        sb_q.push_back(32'h1200);
        exp_count++;
        step();
        r_valid = 2'b10;  r_pc[1] = 32'h1400;  r_stage[1] = 3'd4;
        void'(sb_q.pop_back());
        sb_q.push_back(32'h1400);
        exp_count++;
        @(negedge clk);
        check("pf_mask_c1", 32'(bus.stage_flush), 32'h03);
        step();
        r_valid = 2'b01;  r_pc[0] = 32'h1100;  r_stage[0] = 3'd1;
        @(negedge clk);
        check("pf_mask_c2", 32'(bus.stage_flush), 32'h0f);
        step();
        r_valid = 2'b00;
        @(negedge clk);
        check("pf_mask_c3", 32'(bus.stage_flush), 32'h0f);
        check("pf_nv_c3", 32'(bus.npc_valid), 32'h0);
        step();
        @(negedge clk);
        check("pf_nv_c4", 32'(bus.npc_valid), 32'h1);
        check("pf_npc_c4", bus.npc, 32'h1400);
        step();
        @(negedge clk);
        check("pf_idle", 32'(bus.busy), 32'h0);
        check_counts("pf");

        // Preempt during OFFER with ready high: no handshake that cycle.
        step();
        r_valid = 2'b01;  r_pc[0] = 32'h2100;  r_stage[0] = 3'd1;
        sb_q.push_back(32'h2100);
        exp_count++;
        step();
        r_valid = 2'b00;
        @(negedge clk);
        check("po_mask_c1", 32'(bus.stage_flush), 32'h01);
        step();
        step();
        r_valid = 2'b10;  r_pc[1] = 32'h2300;  r_stage[1] = 3'd3;
        suppress_hs = 1'b1;
        void'(sb_q.pop_back());
        sb_q.push_back(32'h2300);
        exp_count++;
        @(negedge clk);
        check("po_nv_c3", 32'(bus.npc_valid), 32'h1);
        check("po_npc_c3", bus.npc, 32'h2100);
        step();
        r_valid = 2'b00;
        suppress_hs = 1'b0;
        @(negedge clk);
        check("po_nv_c4", 32'(bus.npc_valid), 32'h0);
        check("po_mask_c4", 32'(bus.stage_flush), 32'h07);
        check("po_busy_c4", 32'(bus.busy), 32'h1);
        step();
        step();
        @(negedge clk);
        check("po_nv_c6", 32'(bus.npc_valid), 32'h1);
        check("po_npc_c6", bus.npc, 32'h2300);
        step();
        @(negedge clk);
        check("po_idle", 32'(bus.busy), 32'h0);
        check_counts("po");
        check("sb_drained", 32'(sb_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
